// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin write arbiter for a bank of eight enable registers.
//            Four requesters share one write bus. Each write takes a
//            three-cycle slot: IDLE (arbitrate), GRANT (drive en/data/ack),
//            RECOVER (dead cycle).
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [3:0]         req,
    input  logic [11:0]        req_addr,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [7:0]         reg_en,
    output logic [WIDTH-1:0]   wr_data,
    output logic [3:0]         ack,
    output logic [1:0]         grant_id,
    output logic               busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_ptr;

    logic             w_found;
    logic [1:0]       w_win;
    logic [2:0]       w_addr;
    logic [WIDTH-1:0] w_data;

    // Rotating priority search: scan from the farthest offset back to the
    // pointer so the closest set bit to r_ptr is the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[r_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 2'(i);
            end
        end
    end

    // Select the winner's address and data fields from the packed buses.
    always_comb begin
        w_addr = 3'd0;
        w_data = '0;
        case (w_win)
            2'd0: begin
                w_addr = req_addr[2:0];
                w_data = req_data[0*WIDTH +: WIDTH];
            end
            2'd1: begin
                w_addr = req_addr[5:3];
                w_data = req_data[1*WIDTH +: WIDTH];
            end
            2'd2: begin
                w_addr = req_addr[8:6];
                w_data = req_data[2*WIDTH +: WIDTH];
            end
            default: begin
                w_addr = req_addr[11:9];
                w_data = req_data[3*WIDTH +: WIDTH];
            end
        endcase
    end

    // Sequencer: capture the winner on IDLE->GRANT directly into the output
    // registers, so outputs never depend combinationally on req.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            reg_en   <= 8'd0;
            wr_data  <= '0;
            ack      <= 4'd0;
            grant_id <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state  <= S_GRANT;
                        r_ptr    <= w_win + 2'd1;
                        reg_en   <= 8'd1 << w_addr;
                        wr_data  <= w_data;
                        ack      <= 4'd1 << w_win;
                        grant_id <= w_win;
                    end
                end
                S_GRANT: begin
                    r_state <= S_RECOVER;
                    reg_en  <= 8'd0;
                    wr_data <= '0;
                    ack     <= 4'd0;
                end
                S_RECOVER: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    reg_en  <= 8'd0;
                    wr_data <= '0;
                    ack     <= 4'd0;
                end
            endcase
        end
    end

    // Busy covers the GRANT and RECOVER cycles; derived from the state register.
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Directed self-checking bench for reg_write_arbiter with a model
//            of the eight-register bank it feeds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    logic        clk;
    logic        clear;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic [7:0]  reg_en;
    logic [7:0]  wr_data;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;

    int n_vec;
    int n_err;

    logic [7:0] model_reg [8];

    reg_write_arbiter #(.WIDTH(8)) dut (
        .clk      (clk),
        .clear    (clear),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .reg_en   (reg_en),
        .wr_data  (wr_data),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: shared clear, loads d_in when its en is high.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (clear)
                model_reg[k] <= 8'h00;
            else if (reg_en[k])
                model_reg[k] <= wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] e_en,
                             input logic [7:0] e_data, input logic [3:0] e_ack,
                             input logic [1:0] e_id);
        chk({tag, "_en"},   32'(reg_en),   32'(e_en));
        chk({tag, "_data"}, 32'(wr_data),  32'(e_data));
        chk({tag, "_ack"},  32'(ack),      32'(e_ack));
        chk({tag, "_id"},   32'(grant_id), 32'(e_id));
        chk({tag, "_busy"}, 32'(busy),     32'd1);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        clear    = 1'b1;
        req      = 4'b1111;
        req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
        req_data = 32'h13121110;

        // Reset held two cycles with all requests up.
        tick();
        tick();
        chk("rst_en",   32'(reg_en),   32'd0);
        chk("rst_data", 32'(wr_data),  32'd0);
        chk("rst_ack",  32'(ack),      32'd0);
        chk("rst_id",   32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy),     32'd0);

        // First grant after release goes to requester 0.
        clear = 1'b0;
        tick();
        chk_grant("rst_first", 8'b0000_0001, 8'h10, 4'b0001, 2'd0);
        req = 4'b0000;
        tick();
        tick();

        // Single write: requester 2, addr 5, data A5 (ptr is 1).
        req      = 4'b0100;
        req_addr = {3'd0, 3'd5, 3'd0, 3'd0};
        req_data = 32'h00A50000;
        tick();
        chk_grant("single", 8'b0010_0000, 8'hA5, 4'b0100, 2'd2);
        req = 4'b0000;
        tick();
        chk("single_rec_busy", 32'(busy),         32'd1);
        chk("single_rec_en",   32'(reg_en),       32'd0);
        chk("single_rec_ack",  32'(ack),          32'd0);
        chk("single_rec_data", 32'(wr_data),      32'd0);
        chk("single_reg5",     32'(model_reg[5]), 32'hA5);
        tick();
        chk("single_idle_busy", 32'(busy),     32'd0);
        chk("single_hold_id",   32'(grant_id), 32'd2);

        // Full contention from ptr = 0: grants 0,1,2,3 every three cycles.
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        req      = 4'b1111;
        req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
        req_data = 32'h13121110;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk_grant($sformatf("cont%0d", g), 8'(8'd1 << g), 8'(8'h10 + g),
                      4'(4'd1 << g), 2'(g));
            req[g] = 1'b0;
            tick();
            tick();
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("cont_reg%0d", k), 32'(model_reg[k]), 32'(8'h10 + k));

        // Wrap: ptr is 0 after grant to 3; requesters 0 and 3 contend.
        req      = 4'b1001;
        req_addr = {3'd6, 3'd0, 3'd0, 3'd6};
        req_data = 32'h3C00000C;
        tick();
        chk_grant("wrap0", 8'b0100_0000, 8'h0C, 4'b0001, 2'd0);
        req = 4'b1000;
        tick();
        tick();
        tick();
        chk_grant("wrap3", 8'b0100_0000, 8'h3C, 4'b1000, 2'd3);
        chk("wrap_reg6_pre", 32'(model_reg[6]), 32'h0C);
        // Requester 3 stays up through its ack; requester 1 arrives.
        req      = 4'b1010;
        req_addr = {3'd6, 3'd0, 3'd2, 3'd0};
        req_data = 32'h3D00_5100;
        tick();
        chk("wrap_reg6", 32'(model_reg[6]), 32'h3C);
        tick();
        tick();
        chk_grant("fair1", 8'b0000_0100, 8'h51, 4'b0010, 2'd1);
        req = 4'b1000;
        tick();
        tick();
        tick();
        chk_grant("fair3", 8'b0100_0000, 8'h3D, 4'b1000, 2'd3);
        req = 4'b0000;
        tick();
        tick();

        // Reset in the GRANT cycle of a write by requester 1 to addr 7.
        req      = 4'b0010;
        req_addr = {3'd0, 3'd0, 3'd7, 3'd0};
        req_data = 32'h0000_7700;
        tick();
        chk_grant("mid", 8'b1000_0000, 8'h77, 4'b0010, 2'd1);
        clear = 1'b1;
        req   = 4'b0000;
        tick();
        chk("mid_en",   32'(reg_en),       32'd0);
        chk("mid_ack",  32'(ack),          32'd0);
        chk("mid_busy", 32'(busy),         32'd0);
        chk("mid_id",   32'(grant_id),     32'd0);
        chk("mid_reg7", 32'(model_reg[7]), 32'd0);

        // Collision on addr 4 by requesters 1 and 2; ptr=0 means 1 goes first.
        clear    = 1'b0;
        req      = 4'b0110;
        req_addr = {3'd0, 3'd4, 3'd4, 3'd0};
        req_data = 32'h0022_1100;
        tick();
        chk_grant("coll1", 8'b0001_0000, 8'h11, 4'b0010, 2'd1);
        req = 4'b0100;
        tick();
        chk("coll_reg4_a", 32'(model_reg[4]), 32'h11);
        tick();
        tick();
        chk_grant("coll2", 8'b0001_0000, 8'h22, 4'b0100, 2'd2);
        req = 4'b0000;
        tick();
        chk("coll_reg4_b", 32'(model_reg[4]), 32'h22);
        tick();
        tick();
        chk("final_idle_en", 32'(reg_en), 32'd0);
        chk("final_busy",    32'(busy),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
